l1_l2_arbiter: RTL and testbench

Arbitrates between the L1 instruction cache and L1 data cache miss ports and presents a single line-granular request stream to the L2 cache. It sits directly downstream of both L1 caches and upstream of L2. It also drives the `l2_access`/`l2_resp` strobes that the cache statistics block samples. One requester is served at a time, and each request runs to completion before the next grant.

---
 rtl/arb_pkg.sv | 23 ++
 rtl/l1_l2_arbiter_ctrl.sv | 95 +++++++++
 rtl/l1_l2_arbiter.sv | 87 ++++++++
 tb/tb_l1_l2_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// arb_pkg
// Shared types and default widths for the L1 -> L2 arbiter.
//   arb_state_t : arbiter FSM states (idle, serving I-cache, serving D-cache)
//   arb_grant_t : which requester was granted most recently
//   ARB_ADDR_W  : default byte address width
//   ARB_LINE_W  : default cache line width in bits
package arb_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_LINE_W = 256;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_SERVE_I,
        ARB_SERVE_D
    } arb_state_t;

    typedef enum logic {
        GRANT_I,
        GRANT_D
    } arb_grant_t;

endpackage

// File: rtl/l1_l2_arbiter_ctrl.sv
// l1_l2_arbiter_ctrl
// Grant FSM for the L1 -> L2 arbiter. Picks one requester from idle, holds the
// grant until L2 completes, then returns to idle for one bubble cycle.
// Optional feature macro: ARB_ROUND_ROBIN_EN (alternating tie-break using
// last_grant); when undefined the D-cache always wins ties.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   i_req       : I-cache wants service
//   d_req       : D-cache wants service (read or writeback)
//   l2_resp     : L2 completion strobe
//   state       : current FSM state (drives the datapath muxes in the top)
//   i_resp_en   : I-cache request completes this cycle
//   d_resp_en   : D-cache request completes this cycle
module l1_l2_arbiter_ctrl
    import arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_req,
    input  logic       d_req,
    input  logic       l2_resp,
    output arb_state_t state,
    output logic       i_resp_en,
    output logic       d_resp_en
);

    arb_state_t next_state;
    logic       d_wins_tie;

`ifdef ARB_ROUND_ROBIN_EN
    arb_grant_t last_grant;

    // Remember the requester of the most recently completed grant so the
    // other one wins the next tie. Resetting to I makes the first tie go to D.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= GRANT_I;
        end else if (l2_resp) begin
            if (state == ARB_SERVE_I) begin
                last_grant <= GRANT_I;
            end else if (state == ARB_SERVE_D) begin
                last_grant <= GRANT_D;
            end
        end
    end

    assign d_wins_tie = (last_grant == GRANT_I);
`else
    assign d_wins_tie = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A grant is held until L2 completes, even if the requester drops its
    // request; completion always passes through idle, giving the bubble.
    always_comb begin
        next_state = state;
        case (state)
            ARB_IDLE: begin
                if (i_req && d_req) begin
                    next_state = d_wins_tie ? ARB_SERVE_D : ARB_SERVE_I;
                end else if (d_req) begin
                    next_state = ARB_SERVE_D;
                end else if (i_req) begin
                    next_state = ARB_SERVE_I;
                end
            end
            ARB_SERVE_I,
            ARB_SERVE_D: begin
                if (l2_resp) begin
                    next_state = ARB_IDLE;
                end
            end
            default: next_state = ARB_IDLE;
        endcase
    end

    // Completion is combinational from l2_resp; suppressed while reset is
    // asserted so an aborted transaction never reports completion.
    always_comb begin
        i_resp_en = 1'b0;
        d_resp_en = 1'b0;
        if (!rst && l2_resp) begin
            i_resp_en = (state == ARB_SERVE_I);
            d_resp_en = (state == ARB_SERVE_D);
        end
    end

endmodule

// File: rtl/l1_l2_arbiter.sv
// l1_l2_arbiter
// Merges the L1 I-cache and D-cache miss ports into one line-granular L2
// request stream, one transaction at a time.
// Optional feature macro: ARB_ROUND_ROBIN_EN (see l1_l2_arbiter_ctrl).
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   i_read, i_addr               : I-cache line read request
//   i_rdata, i_resp              : I-cache returned line / completion
//   d_read, d_write, d_addr      : D-cache read / writeback request
//   d_wdata                      : D-cache writeback line
//   d_rdata, d_resp              : D-cache returned line / completion
//   l2_read, l2_write, l2_addr   : L2 request
//   l2_wdata                     : L2 write line
//   l2_rdata, l2_resp            : L2 returned line / completion
//   l2_access                    : any L2 request active, for statistics
module l1_l2_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int LINE_W = ARB_LINE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              l2_read,
    output logic              l2_write,
    output logic [ADDR_W-1:0] l2_addr,
    output logic [LINE_W-1:0] l2_wdata,
    input  logic [LINE_W-1:0] l2_rdata,
    input  logic              l2_resp,
    output logic              l2_access
);

    arb_state_t state;
    logic       serve_i;
    logic       serve_d;

    l1_l2_arbiter_ctrl u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_read),
        .d_req     (d_read | d_write),
        .l2_resp   (l2_resp),
        .state     (state),
        .i_resp_en (i_resp),
        .d_resp_en (d_resp)
    );

    // Datapath is quiet while reset is held, so an abort drops the L2
    // strobes immediately rather than one cycle later.
    assign serve_i = !rst && (state == ARB_SERVE_I);
    assign serve_d = !rst && (state == ARB_SERVE_D);

    // Read data fans out unqualified; only *_resp marks it valid.
    assign i_rdata = l2_rdata;
    assign d_rdata = l2_rdata;

    // The granted requester's request lines pass straight through, including
    // the illegal d_read+d_write combination, which is not filtered.
    always_comb begin
        l2_read  = 1'b0;
        l2_write = 1'b0;
        l2_addr  = '0;
        l2_wdata = '0;
        if (serve_i) begin
            l2_read = i_read;
            l2_addr = i_addr;
        end else if (serve_d) begin
            l2_read  = d_read;
            l2_write = d_write;
            l2_addr  = d_addr;
            l2_wdata = d_wdata;
        end
    end

    assign l2_access = l2_read | l2_write;

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// tb_l1_l2_arbiter
// Directed testbench for l1_l2_arbiter. Inputs change on the falling edge and
// outputs are compared 1 time unit later, away from the rising edge.
// Tie-break expectations follow ARB_ROUND_ROBIN_EN when it is defined.
module tb_l1_l2_arbiter;
    import arb_pkg::*;

    localparam int AW = 32;
    localparam int LW = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_read;
    logic [AW-1:0] i_addr;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_addr;
    logic [LW-1:0] d_wdata;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic          l2_read;
    logic          l2_write;
    logic [AW-1:0] l2_addr;
    logic [LW-1:0] l2_wdata;
    logic [LW-1:0] l2_rdata;
    logic          l2_resp;
    logic          l2_access;

    int checks = 0;
    int errors = 0;

    l1_l2_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_read    (i_read),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_resp    (i_resp),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_resp    (d_resp),
        .l2_read   (l2_read),
        .l2_write  (l2_write),
        .l2_addr   (l2_addr),
        .l2_wdata  (l2_wdata),
        .l2_rdata  (l2_rdata),
        .l2_resp   (l2_resp),
        .l2_access (l2_access)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One cycle of stimulus: drive on the falling edge, settle, return.
    task automatic applyStimulus(input logic ir, input logic dr, input logic dw,
                                 input logic [AW-1:0] ia, input logic [AW-1:0] da,
                                 input logic [LW-1:0] wd, input logic resp,
                                 input logic [LW-1:0] rd);
        @(negedge clk);
        i_read   = ir;
        d_read   = dr;
        d_write  = dw;
        i_addr   = ia;
        d_addr   = da;
        d_wdata  = wd;
        l2_resp  = resp;
        l2_rdata = rd;
        #1;
    endtask

    logic [LW-1:0] line_a5;
    logic [LW-1:0] line_wd;
    logic          exp_d [3];
    int            acc_cycles;
    int            resp_pulses;

    initial begin
        line_a5 = {32{8'hA5}};
        line_wd = {8{32'h12345678}};
`ifdef ARB_ROUND_ROBIN_EN
        exp_d = '{1'b1, 1'b0, 1'b1};
`else
        exp_d = '{1'b1, 1'b1, 1'b1};
`endif
        rst      = 1'b1;
        i_read   = 1'b0;
        d_read   = 1'b0;
        d_write  = 1'b0;
        i_addr   = '0;
        d_addr   = '0;
        d_wdata  = '0;
        l2_resp  = 1'b0;
        l2_rdata = '0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_l2_read", l2_read, 0);
        checkOutput("rst_l2_write", l2_write, 0);
        checkOutput("rst_l2_access", l2_access, 0);
        checkOutput("rst_l2_addr", l2_addr, 0);
        checkOutput("rst_l2_wdata", l2_wdata, 0);
        checkOutput("rst_i_resp", i_resp, 0);
        checkOutput("rst_d_resp", d_resp, 0);
        rst = 1'b0;

        // I-only read, L2 answers 3 cycles after l2_read rises
        applyStimulus(1, 0, 0, 32'h100, 0, 0, 0, 0);
        checkOutput("i_idle_l2_read", l2_read, 0);
        applyStimulus(1, 0, 0, 32'h100, 0, 0, 0, 0);
        checkOutput("i_l2_read", l2_read, 1);
        checkOutput("i_l2_write", l2_write, 0);
        checkOutput("i_l2_addr", l2_addr, 32'h100);
        checkOutput("i_l2_wdata", l2_wdata, 0);
        checkOutput("i_l2_access", l2_access, 1);
        applyStimulus(1, 0, 0, 32'h100, 0, 0, 0, 0);
        checkOutput("i_wait_resp", i_resp, 0);
        applyStimulus(1, 0, 0, 32'h100, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 32'h100, 0, 0, 1, line_a5);
        checkOutput("i_resp", i_resp, 1);
        checkOutput("i_rdata", i_rdata, line_a5);
        checkOutput("i_d_resp", d_resp, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("i_bubble_resp", i_resp, 0);
        checkOutput("i_bubble_read", l2_read, 0);

        // D writeback
        applyStimulus(0, 0, 1, 0, 32'h2000, line_wd, 0, 0);
        checkOutput("d_idle_l2_write", l2_write, 0);
        applyStimulus(0, 0, 1, 0, 32'h2000, line_wd, 0, 0);
        checkOutput("d_l2_write", l2_write, 1);
        checkOutput("d_l2_read", l2_read, 0);
        checkOutput("d_l2_addr", l2_addr, 32'h2000);
        checkOutput("d_l2_wdata", l2_wdata, line_wd);
        applyStimulus(0, 0, 1, 0, 32'h2000, line_wd, 1, ~line_a5);
        checkOutput("d_resp", d_resp, 1);
        checkOutput("d_rdata", d_rdata, ~line_a5);
        checkOutput("d_i_resp", i_resp, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("d_bubble_resp", d_resp, 0);

        // Three consecutive ties: D re-posts through each bubble, I holds
        applyStimulus(1, 1, 0, 32'h300, 32'h400, 0, 0, 0);
        for (int t = 0; t < 3; t++) begin
            applyStimulus(1, 1, 0, 32'h300, 32'h400, 0, 0, 0);
            checkOutput($sformatf("tie%0d_addr", t), l2_addr, exp_d[t] ? 32'h400 : 32'h300);
            checkOutput($sformatf("tie%0d_read", t), l2_read, 1);
            applyStimulus(1, 1, 0, 32'h300, 32'h400, 0, 1, {8{32'(t)}});
            checkOutput($sformatf("tie%0d_d_resp", t), d_resp, exp_d[t]);
            checkOutput($sformatf("tie%0d_i_resp", t), i_resp, !exp_d[t]);
            applyStimulus(1, (t < 2), 0, 32'h300, 32'h400, 0, 0, 0);
            checkOutput($sformatf("tie%0d_bubble", t), l2_access, 0);
        end
        applyStimulus(1, 0, 0, 32'h300, 32'h400, 0, 0, 0);
        checkOutput("drain_addr", l2_addr, 32'h300);
        checkOutput("drain_read", l2_read, 1);
        applyStimulus(1, 0, 0, 32'h300, 32'h400, 0, 1, line_a5);
        checkOutput("drain_i_resp", i_resp, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset in the middle of a D read aborts it silently
        applyStimulus(0, 1, 0, 0, 32'h500, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 32'h500, 0, 0, 0);
        checkOutput("abort_pre_read", l2_read, 1);
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 32'h500, 0, 0, 0);
        rst = 1'b0;
        #1;
        checkOutput("abort_l2_read", l2_read, 0);
        checkOutput("abort_l2_access", l2_access, 0);
        checkOutput("abort_l2_addr", l2_addr, 0);
        applyStimulus(0, 0, 0, 0, 32'h500, 0, 1, line_a5);
        checkOutput("abort_d_resp", d_resp, 0);
        checkOutput("abort_i_resp", i_resp, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        // Stats hookup: 4 reads, 2-cycle L2 latency each
        acc_cycles  = 0;
        resp_pulses = 0;
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 4; c++) begin
                applyStimulus(c < 3, 0, 0, 32'h600 + 32'(k * 32), 0, 0, c == 2, 0);
                acc_cycles  += int'(l2_access);
                resp_pulses += int'(i_resp);
            end
        end
        checkOutput("stats_access_cycles", acc_cycles, 8);
        checkOutput("stats_resp_pulses", resp_pulses, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
